// File: rtl/mips_mem_responder_if.sv
// Request/response bundle between the multicycle
// core and its word-addressed memory responder.
interface mips_mem_responder_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ready,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ready,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/mips_mem_responder.sv
// Word memory with a fixed-latency request/response
// handshake for a multicycle MIPS-style core.
module mips_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 rst,
  mips_mem_responder_if.slave  bus,
  output logic [1:0]           state
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } st_t;

  st_t         st;
  st_t         nxt;
  logic [3:0]  cnt;

  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;

  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        s_fault;
  logic        l_fault;
  logic        commit;

  logic [31:0] mem [DEPTH];

  // With zero latency RESP is entered on the accepting
  // edge, so the write must come straight from the bus.
  always_comb begin
    s_we    = l_we;
    s_addr  = l_addr;
    s_wdata = l_wdata;
    s_be    = l_be;
    if (st == IDLE) begin
      s_we    = bus.mem_we;
      s_addr  = bus.mem_addr;
      s_wdata = bus.mem_wdata;
      s_be    = bus.mem_be;
    end
  end

  always_comb begin
    s_fault = (s_addr[1:0] != 2'b00) ||
              (s_addr[31:2] >= 30'(DEPTH));
    l_fault = (l_addr[1:0] != 2'b00) ||
              (l_addr[31:2] >= 30'(DEPTH));
    commit  = rst && (nxt == RESP) &&
              (st != RESP) && s_we && !s_fault;
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      cnt     <= 4'd0;
      l_we    <= 1'b0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_be    <= 4'd0;
    end else begin
      st <= nxt;
      if (st == IDLE && bus.mem_req) begin
        cnt     <= 4'(LATENCY);
        l_we    <= bus.mem_we;
        l_addr  <= bus.mem_addr;
        l_wdata <= bus.mem_wdata;
        l_be    <= bus.mem_be;
      end else if (st == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    nxt = IDLE;
    unique case (st)
      IDLE: begin
        if (bus.mem_req)
          nxt = (LATENCY > 0) ? WAIT : RESP;
      end
      WAIT: nxt = (cnt <= 4'd1) ? RESP : WAIT;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (s_be[i])
          mem[s_addr[IW+1:2]][8*i +: 8] <=
            s_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bus.mem_ready = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = 32'd0;
    if (st == RESP) begin
      bus.mem_ready = 1'b1;
      unique case (1'b1)
        l_fault:
          bus.mem_err = 1'b1;
        !l_fault && l_we: begin
        end
        !l_fault && !l_we:
          bus.mem_rdata = mem[l_addr[IW+1:2]];
        default: begin
        end
      endcase
    end
  end

  assign state = st;
endmodule
